// File: rtl/fight_pkg.sv
`default_nettype none
//============================================================================
// fight_pkg : shared attack-state type, timing and combat constants
// Rev 1.0
//============================================================================
package fight_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDUP  = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } attack_state_t;

    localparam int WINDUP_FRAMES  = 4;
    localparam int RECOVER_FRAMES = 8;
    localparam int HIT_RANGE      = 150;
    localparam int DAMAGE         = 10;
    localparam int KB_FRAMES      = 6;
    localparam int KB_FULL        = 4;
    localparam int KB_BLOCK       = 2;
    localparam int MAX_HEALTH     = 100;
    localparam int WALL_LEFT      = 10;
    localparam int WALL_RIGHT     = 504;

    localparam int X_W      = 10;
    localparam int HEALTH_W = 7;
    localparam int KB_CNT_W = 3;
    localparam int PHASE_W  = 3;

    function automatic logic [HEALTH_W-1:0] health_after_hit(input logic [HEALTH_W-1:0] health);
        return (health > HEALTH_W'(DAMAGE)) ? health - HEALTH_W'(DAMAGE) : '0;
    endfunction

    function automatic int kb_magnitude(input logic blocked);
        return blocked ? KB_BLOCK : KB_FULL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/knockback_ctrl_if.sv
`default_nettype none
//============================================================================
// knockback_ctrl_if : fighter inputs and combat outputs of knockback_ctrl
// Rev 1.0
//============================================================================
interface knockback_ctrl_if;
    import fight_pkg::*;

    logic                GamePlaying;
    logic [X_W-1:0]      RyuX;
    logic [X_W-1:0]      AkumaX;
    logic                RyuAttack;
    logic                AkumaAttack;
    logic                RyuCrouch;
    logic                AkumaCrouch;
    int                  XDist;
    int                  Ryu_Knockback;
    int                  Akuma_Knockback;
    logic [HEALTH_W-1:0] RyuHealth;
    logic [HEALTH_W-1:0] AkumaHealth;
    logic                KO;

    modport master (
        output GamePlaying, RyuX, AkumaX, RyuAttack, AkumaAttack, RyuCrouch, AkumaCrouch,
        input  XDist, Ryu_Knockback, Akuma_Knockback, RyuHealth, AkumaHealth, KO
    );

    modport slave (
        input  GamePlaying, RyuX, AkumaX, RyuAttack, AkumaAttack, RyuCrouch, AkumaCrouch,
        output XDist, Ryu_Knockback, Akuma_Knockback, RyuHealth, AkumaHealth, KO
    );

endinterface
`default_nettype wire

// File: rtl/attack_fsm.sv
`default_nettype none
//============================================================================
// attack_fsm : per-fighter press detect and IDLE/WINDUP/ACTIVE/RECOVER timing
// Rev 1.0
//============================================================================
module attack_fsm
    import fight_pkg::*;
(
    input  wire  frame_clk,
    input  wire  Reset,
    input  wire  i_enable,
    input  wire  i_flush,
    input  wire  i_attack,
    output logic o_active
);

    attack_state_t      r_state;
    logic [PHASE_W-1:0] r_phase;
    logic               r_attack_d;
    logic               r_active;
    logic               w_press;

    assign w_press  = i_attack && !r_attack_d;
    assign o_active = r_active;

    // A paused round freezes everything, including the press history.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_attack_d <= 1'b0;
            r_active   <= 1'b0;
        end else if (i_enable) begin
            r_attack_d <= i_attack;
            r_active   <= 1'b0;
            if (i_flush) begin
                r_state <= IDLE;
                r_phase <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_press) begin
                            r_state <= WINDUP;
                            r_phase <= '0;
                        end
                    end
                    WINDUP: begin
                        if (r_phase == PHASE_W'(WINDUP_FRAMES - 1)) begin
                            r_state  <= ACTIVE;
                            r_phase  <= '0;
                            r_active <= 1'b1;
                        end else begin
                            r_phase <= r_phase + PHASE_W'(1);
                        end
                    end
                    ACTIVE: begin
                        r_state <= RECOVER;
                        r_phase <= '0;
                    end
                    RECOVER: begin
                        if (r_phase == PHASE_W'(RECOVER_FRAMES - 1)) begin
                            r_state <= IDLE;
                            r_phase <= '0;
                        end else begin
                            r_phase <= r_phase + PHASE_W'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_phase <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/knockback_ctrl.sv
`default_nettype none
//============================================================================
// knockback_ctrl : hit resolution, health, knockback timing and KO latch
// Rev 1.0
//============================================================================
module knockback_ctrl
    import fight_pkg::*;
(
    input  wire             frame_clk,
    input  wire             Reset,
    knockback_ctrl_if.slave bus
);

    logic                w_ryu_active;
    logic                w_akuma_active;
    int                  w_xdist;
    logic                w_in_range;
    logic                w_ryu_hits;
    logic                w_akuma_hits;

    logic [KB_CNT_W-1:0] r_ryu_kb_cnt,   w_ryu_kb_cnt_nxt;
    logic [KB_CNT_W-1:0] r_akuma_kb_cnt, w_akuma_kb_cnt_nxt;
    logic                r_ryu_kb_blk,   w_ryu_kb_blk_nxt;
    logic                r_akuma_kb_blk, w_akuma_kb_blk_nxt;
    logic [HEALTH_W-1:0] r_ryu_health,   w_ryu_health_nxt;
    logic [HEALTH_W-1:0] r_akuma_health, w_akuma_health_nxt;
    logic                r_ko,           w_ko_nxt;
    int                  r_ryu_kb,       w_ryu_kb_nxt;
    int                  r_akuma_kb,     w_akuma_kb_nxt;

    attack_fsm u_ryu_fsm (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .i_enable  (bus.GamePlaying),
        .i_flush   (r_ko),
        .i_attack  (bus.RyuAttack),
        .o_active  (w_ryu_active)
    );

    attack_fsm u_akuma_fsm (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .i_enable  (bus.GamePlaying),
        .i_flush   (r_ko),
        .i_attack  (bus.AkumaAttack),
        .o_active  (w_akuma_active)
    );

    assign w_xdist      = int'(bus.AkumaX) - int'(bus.RyuX);
    assign w_in_range   = (w_xdist <= HIT_RANGE);
    // A defender still being pushed back cannot be hit again.
    assign w_ryu_hits   = w_ryu_active   && w_in_range && (r_akuma_kb_cnt == '0);
    assign w_akuma_hits = w_akuma_active && w_in_range && (r_ryu_kb_cnt   == '0);

    always_comb begin
        w_akuma_health_nxt = r_akuma_health;
        w_akuma_kb_cnt_nxt = r_akuma_kb_cnt;
        w_akuma_kb_blk_nxt = r_akuma_kb_blk;
        w_ryu_health_nxt   = r_ryu_health;
        w_ryu_kb_cnt_nxt   = r_ryu_kb_cnt;
        w_ryu_kb_blk_nxt   = r_ryu_kb_blk;
        w_akuma_kb_nxt     = 0;
        w_ryu_kb_nxt       = 0;

        if (w_ryu_hits) begin
            w_akuma_kb_cnt_nxt = KB_CNT_W'(KB_FRAMES);
            w_akuma_kb_blk_nxt = bus.AkumaCrouch;
            if (!bus.AkumaCrouch) begin
                w_akuma_health_nxt = health_after_hit(r_akuma_health);
            end
        end else if (r_akuma_kb_cnt != '0) begin
            w_akuma_kb_cnt_nxt = r_akuma_kb_cnt - KB_CNT_W'(1);
        end

        if (w_akuma_hits) begin
            w_ryu_kb_cnt_nxt = KB_CNT_W'(KB_FRAMES);
            w_ryu_kb_blk_nxt = bus.RyuCrouch;
            if (!bus.RyuCrouch) begin
                w_ryu_health_nxt = health_after_hit(r_ryu_health);
            end
        end else if (r_ryu_kb_cnt != '0) begin
            w_ryu_kb_cnt_nxt = r_ryu_kb_cnt - KB_CNT_W'(1);
        end

        w_ko_nxt = (w_ryu_health_nxt == '0) || (w_akuma_health_nxt == '0);

        // Walls suppress the push but the counter keeps running.
        if (!w_ko_nxt && (w_akuma_kb_cnt_nxt != '0) && (bus.AkumaX < X_W'(WALL_RIGHT))) begin
            w_akuma_kb_nxt = kb_magnitude(w_akuma_kb_blk_nxt);
        end
        if (!w_ko_nxt && (w_ryu_kb_cnt_nxt != '0) && (bus.RyuX > X_W'(WALL_LEFT))) begin
            w_ryu_kb_nxt = -kb_magnitude(w_ryu_kb_blk_nxt);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_ryu_kb_cnt   <= '0;
            r_akuma_kb_cnt <= '0;
            r_ryu_kb_blk   <= 1'b0;
            r_akuma_kb_blk <= 1'b0;
            r_ryu_health   <= HEALTH_W'(MAX_HEALTH);
            r_akuma_health <= HEALTH_W'(MAX_HEALTH);
            r_ko           <= 1'b0;
            r_ryu_kb       <= 0;
            r_akuma_kb     <= 0;
        end else if (bus.GamePlaying && !r_ko) begin
            r_ryu_kb_cnt   <= w_ryu_kb_cnt_nxt;
            r_akuma_kb_cnt <= w_akuma_kb_cnt_nxt;
            r_ryu_kb_blk   <= w_ryu_kb_blk_nxt;
            r_akuma_kb_blk <= w_akuma_kb_blk_nxt;
            r_ryu_health   <= w_ryu_health_nxt;
            r_akuma_health <= w_akuma_health_nxt;
            r_ko           <= w_ko_nxt;
            r_ryu_kb       <= w_ryu_kb_nxt;
            r_akuma_kb     <= w_akuma_kb_nxt;
        end else begin
            r_ryu_kb   <= 0;
            r_akuma_kb <= 0;
            if (r_ko) begin
                r_ryu_kb_cnt   <= '0;
                r_akuma_kb_cnt <= '0;
            end
        end
    end

    assign bus.XDist           = w_xdist;
    assign bus.Ryu_Knockback   = r_ryu_kb;
    assign bus.Akuma_Knockback = r_akuma_kb;
    assign bus.RyuHealth       = r_ryu_health;
    assign bus.AkumaHealth     = r_akuma_health;
    assign bus.KO              = r_ko;

endmodule
`default_nettype wire

// File: tb/tb_knockback_ctrl.sv
`default_nettype none
//============================================================================
// tb_knockback_ctrl : directed and random frames checked against a frame model
// Rev 1.0
//============================================================================
module tb_knockback_ctrl;

    localparam int T_ACTIVE = 4;       // frames of windup before the active frame
    localparam int T_END    = 4 + 1 + 8;

    logic frame_clk = 1'b0;
    logic Reset;

    knockback_ctrl_if bus ();

    knockback_ctrl dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus.slave)
    );

    always #5 frame_clk = ~frame_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: index 0 = Ryu, 1 = Akuma. m_age = frames since press edge, -1 when idle.
    int m_age [2];
    int m_kb  [2];
    bit m_blk [2];
    int m_hp  [2];
    bit m_prev[2];
    bit m_wall[2];
    bit m_ko;
    bit m_gp;

    task automatic check(input string ctx, input string name,
                         input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0d expected=%0d", ctx, name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_age[i]  = -1;
            m_kb[i]   = 0;
            m_blk[i]  = 1'b0;
            m_hp[i]   = 100;
            m_prev[i] = 1'b0;
            m_wall[i] = 1'b0;
        end
        m_ko = 1'b0;
        m_gp = 1'b0;
    endtask

    function automatic int exp_kb(input int who);
        if (!m_gp || m_ko || m_kb[who] == 0 || m_wall[who]) return 0;
        return (who == 1 ? 1 : -1) * (m_blk[who] ? 2 : 4);
    endfunction

    task automatic model_edge();
        bit atk[2];
        bit cr[2];
        bit hit[2];
        int rx, ax;
        atk[0] = bus.RyuAttack;  atk[1] = bus.AkumaAttack;
        cr[0]  = bus.RyuCrouch;  cr[1]  = bus.AkumaCrouch;
        rx = int'(bus.RyuX);
        ax = int'(bus.AkumaX);
        m_wall[0] = (rx <= 10);
        m_wall[1] = (ax >= 504);
        if (!bus.GamePlaying) begin
            m_gp = 1'b0;
            return;
        end
        m_gp = 1'b1;
        if (m_ko) begin
            for (int i = 0; i < 2; i++) begin
                m_age[i] = -1;
                m_kb[i]  = 0;
                m_prev[i] = atk[i];
            end
            return;
        end
        for (int a = 0; a < 2; a++)
            hit[a] = (m_age[a] == T_ACTIVE) && (ax - rx <= 150) && (m_kb[1-a] == 0);
        for (int d = 0; d < 2; d++) begin
            if (hit[1-d]) begin
                m_kb[d]  = 6;
                m_blk[d] = cr[d];
                if (!cr[d]) m_hp[d] = (m_hp[d] > 10) ? m_hp[d] - 10 : 0;
            end else if (m_kb[d] > 0) begin
                m_kb[d]--;
            end
        end
        if (m_hp[0] == 0 || m_hp[1] == 0) m_ko = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (m_age[i] < 0) begin
                if (atk[i] && !m_prev[i]) m_age[i] = 0;
            end else begin
                m_age[i]++;
                if (m_age[i] >= T_END) m_age[i] = -1;
            end
            m_prev[i] = atk[i];
        end
    endtask

    task automatic check_all(input string ctx);
        check(ctx, "XDist",    bus.XDist, int'(bus.AkumaX) - int'(bus.RyuX));
        check(ctx, "RyuHP",    {25'd0, bus.RyuHealth},   m_hp[0]);
        check(ctx, "AkumaHP",  {25'd0, bus.AkumaHealth}, m_hp[1]);
        check(ctx, "RyuKB",    bus.Ryu_Knockback,   exp_kb(0));
        check(ctx, "AkumaKB",  bus.Akuma_Knockback, exp_kb(1));
        check(ctx, "KO",       {31'd0, bus.KO},     {31'd0, m_ko});
    endtask

    task automatic frame(input string ctx);
        @(posedge frame_clk);
        model_edge();
        #2;
        check_all(ctx);
    endtask

    task automatic frames(input int n, input string ctx);
        repeat (n) frame(ctx);
    endtask

    task automatic do_reset(input string ctx);
        Reset = 1'b1;
        #1;
        model_reset();
        check_all({ctx, "_async"});
        @(posedge frame_clk);
        #2;
        check_all(ctx);
        Reset = 1'b0;
    endtask

    initial begin : main
        int cnt;
        bus.GamePlaying = 1'b1;
        bus.RyuX        = 10'd200;
        bus.AkumaX      = 10'd300;
        bus.RyuAttack   = 1'b0;
        bus.AkumaAttack = 1'b0;
        bus.RyuCrouch   = 1'b0;
        bus.AkumaCrouch = 1'b0;
        Reset           = 1'b1;
        model_reset();
        @(posedge frame_clk);
        #2;
        check("reset", "RyuHP",   {25'd0, bus.RyuHealth},   100);
        check("reset", "AkumaHP", {25'd0, bus.AkumaHealth}, 100);
        check("reset", "KO",      {31'd0, bus.KO},          0);
        check("reset", "AkumaKB", bus.Akuma_Knockback,      0);
        Reset = 1'b0;

        // Held key: one hit, one 6-frame push.
        bus.RyuAttack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            frame("held");
            if (bus.Akuma_Knockback == 4) cnt++;
        end
        check("held", "kb_frames", cnt, 6);
        check("held", "AkumaHP", {25'd0, bus.AkumaHealth}, 90);
        bus.RyuAttack = 1'b0;
        frames(2, "held_rel");

        // Out of range.
        bus.RyuX = 10'd100;
        bus.RyuAttack = 1'b1;
        frames(16, "miss");
        bus.RyuAttack = 1'b0;
        check("miss", "AkumaHP", {25'd0, bus.AkumaHealth}, 90);

        // Blocked hit by Akuma.
        bus.RyuX = 10'd200; bus.AkumaX = 10'd320; bus.RyuCrouch = 1'b1;
        bus.AkumaAttack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 17; i++) begin
            frame("block");
            bus.AkumaAttack = 1'b0;
            if (bus.Ryu_Knockback == -2) cnt++;
        end
        check("block", "kb_frames", cnt, 6);
        check("block", "RyuHP", {25'd0, bus.RyuHealth}, 100);
        bus.RyuCrouch = 1'b0;

        // Trade.
        bus.AkumaX = 10'd340;
        bus.RyuAttack = 1'b1; bus.AkumaAttack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            frame("trade");
            if (bus.Ryu_Knockback == -4 && bus.Akuma_Knockback == 4) cnt++;
        end
        check("trade", "both_kb", cnt, 6);
        check("trade", "RyuHP",   {25'd0, bus.RyuHealth},   90);
        check("trade", "AkumaHP", {25'd0, bus.AkumaHealth}, 80);
        bus.RyuAttack = 1'b0; bus.AkumaAttack = 1'b0;
        frames(1, "trade_rel");

        // Trade at the right wall.
        bus.RyuX = 10'd370; bus.AkumaX = 10'd510;
        bus.RyuAttack = 1'b1; bus.AkumaAttack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            frame("wall");
            if (bus.Akuma_Knockback != 0) cnt++;
        end
        check("wall", "akuma_kb_frames", cnt, 0);
        check("wall", "AkumaHP", {25'd0, bus.AkumaHealth}, 70);
        bus.RyuAttack = 1'b0; bus.AkumaAttack = 1'b0;
        frames(1, "wall_rel");

        // Pause mid-knockback: 2 frames before, 4 after resume.
        bus.RyuX = 10'd200; bus.AkumaX = 10'd300;
        bus.RyuAttack = 1'b1;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            frame("pause_pre");
            if (bus.Akuma_Knockback != 0) cnt++;
        end
        bus.RyuAttack = 1'b0;
        bus.GamePlaying = 1'b0;
        frames(5, "pause");
        check("pause", "AkumaKB", bus.Akuma_Knockback, 0);
        bus.GamePlaying = 1'b1;
        for (int i = 0; i < 10; i++) begin
            frame("pause_post");
            if (bus.Akuma_Knockback != 0) cnt++;
        end
        check("pause", "kb_frames", cnt, 6);

        // Reset during windup.
        bus.RyuAttack = 1'b1;
        frames(2, "rst_windup_pre");
        bus.RyuAttack = 1'b0;
        do_reset("rst_windup");
        frames(14, "rst_windup_post");
        check("rst_windup", "AkumaHP", {25'd0, bus.AkumaHealth}, 100);

        // Reset on the third knockback frame.
        bus.RyuAttack = 1'b1;
        frames(8, "rst_kb_pre");
        check("rst_kb_pre", "AkumaKB", bus.Akuma_Knockback, 4);
        bus.RyuAttack = 1'b0;
        do_reset("rst_kb");
        frames(10, "rst_kb_post");
        check("rst_kb", "AkumaHP", {25'd0, bus.AkumaHealth}, 100);

        // Random play.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                int rx;
                rx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, 520));
                bus.RyuX   = 10'(rx);
                bus.AkumaX = 10'(rx + int'($urandom_range(0, 250)));
            end
            if ($urandom_range(0, 3) == 0) bus.RyuAttack   = ~bus.RyuAttack;
            if ($urandom_range(0, 3) == 0) bus.AkumaAttack = ~bus.AkumaAttack;
            bus.RyuCrouch   = ($urandom_range(0, 2) == 0);
            bus.AkumaCrouch = ($urandom_range(0, 2) == 0);
            bus.GamePlaying = ($urandom_range(0, 19) != 0);
            frame("rand");
        end

        // Ten unblocked hits to KO, then nothing changes.
        bus.GamePlaying = 1'b1;
        bus.RyuX = 10'd200; bus.AkumaX = 10'd300;
        bus.RyuAttack = 1'b0; bus.AkumaAttack = 1'b0;
        bus.RyuCrouch = 1'b0; bus.AkumaCrouch = 1'b0;
        do_reset("ko_rst");
        for (int k = 0; k < 10; k++) begin
            bus.RyuAttack = 1'b1;
            frame("ko");
            bus.RyuAttack = 1'b0;
            frames(15, "ko");
        end
        check("ko", "AkumaHP", {25'd0, bus.AkumaHealth}, 0);
        check("ko", "KO",      {31'd0, bus.KO},          1);
        for (int k = 0; k < 2; k++) begin
            bus.RyuAttack = 1'b1; bus.AkumaAttack = 1'b1;
            frame("post_ko");
            bus.RyuAttack = 1'b0; bus.AkumaAttack = 1'b0;
            frames(15, "post_ko");
        end
        check("post_ko", "RyuHP", {25'd0, bus.RyuHealth}, 100);
        check("post_ko", "KO",    {31'd0, bus.KO},        1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/knockback_ctrl.md
KNOCKBACK_CTRL -- requirements
Module: knockback_ctrl

Interface
REQ-001 SHALL have port frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port GamePlaying  in  1  1 = round active; 0 = freeze.
REQ-004 SHALL have ports RyuX, AkumaX  in  10 each  fighter left-edge X positions, unsigned pixels; Ryu is always left of Akuma.
REQ-005 SHALL have ports RyuAttack, AkumaAttack  in  1 each  attack key level (held = 1).
REQ-006 SHALL have ports RyuCrouch, AkumaCrouch  in  1 each  defender crouch (block) flags.
REQ-007 SHALL have port XDist  out  int  AkumaX - RyuX, combinational, signed.
REQ-008 SHALL have ports Ryu_Knockback, Akuma_Knockback  out  int each  per-frame X displacement added by the movement blocks; registered.
REQ-009 SHALL have ports RyuHealth, AkumaHealth  out  7 each  health points, registered.
REQ-010 SHALL have port KO  out  1  registered; 1 once either health reaches 0.

Function
REQ-011 SHALL rising-edge-detect each attack input: press = (Attack=1 and previous-frame Attack=0); a held key gives one press.
REQ-012 SHALL run one attack FSM per fighter with states IDLE, WINDUP, ACTIVE, RECOVER.
REQ-013 SHALL move IDLE->WINDUP on press, and ignore presses in any state other than IDLE.
REQ-014 SHALL stay in WINDUP for exactly 4 frames, then ACTIVE for exactly 1 frame, then RECOVER for exactly 8 frames, then return to IDLE.
REQ-015 SHALL score a hit in the ACTIVE frame when XDist <= 150 and the defender's knockback counter is 0; XDist > 150 is a miss.
REQ-016 SHALL, on an unblocked hit (defender crouch = 0), decrement defender health by 10 saturating at 0, and load the defender's knockback counter with 6 at the same edge.
REQ-017 SHALL, on a blocked hit (defender crouch = 1 in the ACTIVE frame), leave health unchanged and load the knockback counter with 6 at reduced magnitude.
REQ-018 SHALL drive knockback while the counter is nonzero, starting the frame after the ACTIVE frame and lasting 6 frames; the counter decrements each frame.
REQ-019 Knockback magnitudes: Akuma_Knockback = +4 unblocked / +2 blocked; Ryu_Knockback = -4 unblocked / -2 blocked; 0 otherwise.
REQ-020 SHALL force Akuma_Knockback to 0 when AkumaX >= 504, and Ryu_Knockback to 0 when RyuX <= 10; the counter keeps decrementing (wall clamp).
REQ-021 SHALL apply both hits independently when both ACTIVE frames coincide and both in range (trade).
REQ-022 SHALL set KO at the edge where either health becomes 0, holding KO until Reset.
REQ-023 While KO = 1: all FSMs SHALL return to IDLE, knockback outputs SHALL be 0, and health SHALL be held.
REQ-024 While GamePlaying = 0: FSMs, counters, health and edge-detect history SHALL hold, and knockback outputs SHALL read 0.

Reset
REQ-025 On Reset: FSMs SHALL be IDLE, counters 0, both knockback outputs 0, RyuHealth = AkumaHealth = 100, KO = 0, edge-detect history 0.
REQ-026 Reset asserted mid-attack or mid-knockback SHALL abort immediately with no further health change.

Structure
REQ-027 SHALL define the following in shared package fight_pkg: the attack-state enum, WINDUP_FRAMES = 4, RECOVER_FRAMES = 8, HIT_RANGE = 150, DAMAGE = 10, KB_FRAMES = 6, KB_FULL = 4, KB_BLOCK = 2, MAX_HEALTH = 100, and wall limits 10 and 504.
REQ-028 SHALL implement the per-fighter edge detect and FSM as sub-module attack_fsm, instantiated twice, with the ACTIVE frame as its output.

Verification
REQ-029 RyuX = 200, AkumaX = 300, Ryu press held 20 frames -> one hit only; AkumaHealth 90; Akuma_Knockback = +4 for 6 frames starting 6 frames after the press edge.
REQ-030 RyuX = 100, AkumaX = 300 (XDist = 200), Ryu press -> no hit; health 100; knockback 0.
REQ-031 Akuma presses with RyuCrouch = 1 in the ACTIVE frame, XDist = 120 -> RyuHealth 100; Ryu_Knockback = -2 for 6 frames.
REQ-032 Both fighters press on the same frame, XDist = 140 -> both health 90; both knockbacks active together; AkumaX = 510 -> Akuma_Knockback = 0.
REQ-033 Ten unblocked Ryu hits -> AkumaHealth 0 and KO = 1 on the 10th hit edge; further presses produce no change.
REQ-034 Reset asserted during WINDUP, and separately during knockback frame 3 -> all outputs return to reset values; GamePlaying = 0 for 5 frames mid-knockback -> knockback outputs 0 and counter resumes where it stopped.
